// File: rtl/alu_pkg.sv
// Shared definitions for the ALU subtract path: FSM states, nibble size
// and an elaboration-time width check.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  // Operand width must split into whole nibbles and hold at least two.
  function automatic bit width_ok(input int w);
    return ((w % NIBBLE) == 0) && (w >= 8);
  endfunction

endpackage

// File: rtl/sub_nibble.sv
// 4-bit combinational subtractor slice: d = a - b - bi, with the borrow out
// of bit 3 and the borrow into bit 3 (the latter feeds overflow detection).
module sub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo,
  output logic       b3
);

  logic [4:0] w_full;
  logic [3:0] w_low;

  // Full nibble difference; the extra MSB is the borrow out.
  always_comb begin
    w_full = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    w_low  = {1'b0, a[2:0]} - {1'b0, b[2:0]} - {3'b0, bi};
    d      = w_full[3:0];
    bo     = w_full[4];
    b3     = w_low[3];
  end

endmodule

// File: rtl/alu_sub_seq.sv
// Sequential WIDTH-bit subtractor: one nibble per cycle, LSB first, borrow
// carried in a register between cycles, valid/ready on both sides.
module alu_sub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_width_err
      $error("alu_sub_seq: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_d;
  logic             w_bo;
  logic             w_b3;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_next;

  // Steer nibble k of the latched operands into the single slice and
  // splice its result into a copy of the partial difference.
  always_comb begin
    w_a_nib     = r_a[r_k*NIBBLE +: NIBBLE];
    w_b_nib     = r_b[r_k*NIBBLE +: NIBBLE];
    w_last      = (r_k == KW'(N - 1));
    w_diff_next = r_diff;
    w_diff_next[r_k*NIBBLE +: NIBBLE] = w_d;
  end

  sub_nibble u_sub_nibble (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo),
    .b3 (w_b3)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone accepts.
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= bin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_diff   <= w_diff_next;
          r_borrow <= w_bo;
          r_k      <= r_k + KW'(1);
          if (w_last) begin
            // Overflow: borrow into the sign bit differs from borrow out.
            r_bout      <= w_bo;
            r_ovf       <= w_b3 ^ w_bo;
            r_zero      <= (w_diff_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
